// File: rtl/projection_matrix_gen.sv
// Sequential 4x4 perspective projection matrix generator. One shared restoring divider
// produces m11, m22, m33 and m34 in turn; the packed matrix is published atomically.
module projection_matrix_gen #(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 5,
    parameter int unsigned DIV_W = 2 * DW + 2 * FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    width_px,
    input  logic [DW-1:0]    height_px,
    input  logic [DW-1:0]    tan_half,
    input  logic [DW-1:0]    z_near,
    input  logic [DW-1:0]    z_far,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mtrx_valid,
    output logic [16*DW-1:0] proj_mtrx
);

    localparam int unsigned CW = $clog2(DIV_W);
    localparam int unsigned PW = 2 * DW;
    localparam logic [CW-1:0]    CntLast = CW'(DIV_W - 1);
    localparam logic [DIV_W-1:0] PosMax  = DIV_W'((1 << (DW - 1)) - 1);
    localparam logic [DIV_W-1:0] NegMag  = DIV_W'(1 << (DW - 1));
    localparam logic [DW-1:0]    SatPos  = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0]    SatNeg  = {1'b1, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0]    OneFix  = DW'(1 << FRAC);

    typedef enum logic [1:0] {StIdle, StCheck, StDiv, StCommit} state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      wid_q, wid_d, hgt_q, hgt_d, tan_q, tan_d;
    logic [DW-1:0]      znear_q, znear_d, zfar_q, zfar_d;
    logic [1:0]         k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]   rem_q, rem_d, quo_q, quo_d, den_q, den_d;
    logic [DW-1:0]      m11_q, m11_d, m22_q, m22_d, m33_q, m33_d, m34_q, m34_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d, valid_q, valid_d;
    logic [16*DW-1:0]   mtrx_q, mtrx_d;

    logic [1:0]         op_sel;
    logic [DW-1:0]      mul_a, mul_b, zdiff;
    logic [PW-1:0]      prod;
    logic [DIV_W-1:0]   op_num, op_den;
    logic [DIV_W:0]     rem_sh, diff;
    logic               ge;
    logic [DIV_W-1:0]   rem_nx, quo_nx;
    logic [DW-1:0]      q_pos, q_neg;
    logic [16*DW-1:0]   mtrx_pack;
    logic               reject;

    // Operands for the division about to be loaded: k0 from CHECK, otherwise k+1.
    always_comb begin
        op_sel = (state_q == StCheck) ? 2'd0 : k_q + 2'd1;
        mul_a  = (op_sel == 2'd0) ? wid_q : zfar_q;
        mul_b  = (op_sel == 2'd0) ? tan_q : znear_q;
        prod   = PW'(mul_a) * PW'(mul_b);
        zdiff  = zfar_q - znear_q;
        op_num = '0;
        op_den = '0;
        unique case (op_sel)
            2'd0: begin
                op_num = DIV_W'(hgt_q) << (2 * FRAC);
                op_den = DIV_W'(prod);
            end
            2'd1: begin
                op_num = DIV_W'(1) << (2 * FRAC);
                op_den = DIV_W'(tan_q);
            end
            2'd2: begin
                op_num = DIV_W'(zfar_q) << FRAC;
                op_den = DIV_W'(zdiff);
            end
            2'd3: begin
                op_num = DIV_W'(prod) << FRAC;
                op_den = DIV_W'(zdiff);
            end
        endcase
    end

    // One restoring step; the borrow bit of diff doubles as the compare result.
    always_comb begin
        rem_sh = {rem_q, quo_q[DIV_W-1]};
        diff   = rem_sh - {1'b0, den_q};
        ge     = ~diff[DIV_W];
        rem_nx = ge ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
        quo_nx = {quo_q[DIV_W-2:0], ge};
        q_pos  = (quo_nx > PosMax) ? SatPos : quo_nx[DW-1:0];
        q_neg  = (quo_nx >= NegMag) ? SatNeg : DW'(0) - quo_nx[DW-1:0];
    end

    always_comb begin
        mtrx_pack = '0;
        mtrx_pack[15*DW +: DW] = m11_q;
        mtrx_pack[10*DW +: DW] = m22_q;
        mtrx_pack[5*DW +: DW]  = m33_q;
        mtrx_pack[4*DW +: DW]  = m34_q;
        mtrx_pack[1*DW +: DW]  = OneFix;
    end

    assign reject = (tan_q == '0) || (wid_q == '0) || (zfar_q <= znear_q);

    always_comb begin
        state_d = state_q;
        wid_d   = wid_q;
        hgt_d   = hgt_q;
        tan_d   = tan_q;
        znear_d = znear_q;
        zfar_d  = zfar_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        m11_d   = m11_q;
        m22_d   = m22_q;
        m33_d   = m33_q;
        m34_d   = m34_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        valid_d = valid_q;
        mtrx_d  = mtrx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    wid_d   = width_px;
                    hgt_d   = height_px;
                    tan_d   = tan_half;
                    znear_d = z_near;
                    zfar_d  = z_far;
                    busy_d  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (reject) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    k_d     = 2'd0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = op_num;
                    den_d   = op_den;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    unique case (k_q)
                        2'd0: m11_d = q_pos;
                        2'd1: m22_d = q_pos;
                        2'd2: m33_d = q_pos;
                        2'd3: m34_d = q_neg;
                    endcase
                    if (k_q == 2'd3) begin
                        state_d = StCommit;
                    end else begin
                        k_d   = k_q + 2'd1;
                        cnt_d = '0;
                        rem_d = '0;
                        quo_d = op_num;
                        den_d = op_den;
                    end
                end
            end
            StCommit: begin
                mtrx_d  = mtrx_pack;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wid_q   <= '0;
            hgt_q   <= '0;
            tan_q   <= '0;
            znear_q <= '0;
            zfar_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            m11_q   <= '0;
            m22_q   <= '0;
            m33_q   <= '0;
            m34_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            mtrx_q  <= '0;
        end else begin
            state_q <= state_d;
            wid_q   <= wid_d;
            hgt_q   <= hgt_d;
            tan_q   <= tan_d;
            znear_q <= znear_d;
            zfar_q  <= zfar_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            m11_q   <= m11_d;
            m22_q   <= m22_d;
            m33_q   <= m33_d;
            m34_q   <= m34_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            mtrx_q  <= mtrx_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mtrx_valid = valid_q;
    assign proj_mtrx  = mtrx_q;

endmodule
